unsigned_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier computing `product = A * B` over `WIDTH` clock cycles with a start/ready handshake. It is the inverse companion of the team's sequential restoring divider and shares its handshake style: single-cycle `start`, `ready` level, and a concatenated double-width result register. It sits beside the divider in the datapath's multi-cycle arithmetic unit.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/unsigned_multiplier_if.sv | 23 ++
 rtl/unsigned_multiplier_shift_add_step.sv | 28 ++
 rtl/unsigned_multiplier.sv | 101 ++++++++++
 tb/tb_unsigned_multiplier.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic unit (multiplier and divider).
// Latency: none (package only).
// Backpressure: none (package only).
package arith_pkg;

  // Default operand width for the sequential arithmetic blocks.
  localparam int unsigned ARITH_WIDTH = 32;

  // Two-state sequencer shared by the multiplier and the divider.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arith_state_e;

  // Width of an iteration counter that must be able to hold the value w.
  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/unsigned_multiplier_if.sv
// Operand/result bundle of the sequential multiplier.
// Latency: none (wires only).
// Backpressure: none; master issues start while the slave reports ready.
//   start   : master -> slave, one-cycle load strobe
//   A, B    : master -> slave, operands sampled on the start edge
//   product : slave -> master, {high, low} result, valid while ready=1
//   ready   : slave -> master, idle/done level
interface unsigned_multiplier_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   product;
  logic                 ready;

  modport master (output start, A, B, input product, ready);
  modport slave  (input start, A, B, output product, ready);

endinterface

// File: rtl/unsigned_multiplier_shift_add_step.sv
// One shift-and-add iteration of the sequential multiplier (combinational).
// Latency: 0 cycles.
// Backpressure: none.
//   product_i      : current {high, low} accumulator; low half still holds unconsumed multiplier bits
//   multiplicand_i : multiplicand added into the high half when product_i[0] is set
//   product_o      : accumulator after one iteration
module shift_add_step
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
) (
  input  logic [2*WIDTH-1:0] product_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  output logic [2*WIDTH-1:0] product_o
);

  // One extra bit so the carry out of the high-half add is kept and
  // shifted back into the accumulator instead of being lost.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, product_i[2*WIDTH-1:WIDTH]}
        + (product_i[0] ? {1'b0, multiplicand_i} : {(WIDTH+1){1'b0}});
    // The consumed multiplier bit drops off the bottom as everything shifts right.
    product_o = {sum, product_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/unsigned_multiplier.sv
// Sequential unsigned shift-and-add multiplier, product = A * B over WIDTH cycles.
// Latency: WIDTH cycles from the start edge to ready; with
//   UNSIGNED_MULTIPLIER_EARLY_EXIT_EN defined, it finishes as soon as the remaining multiplier bits are zero.
// Backpressure: none; start is accepted in any state and abandons an in-flight multiply.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of unsigned_multiplier_if (start, A, B in; product, ready out)
module unsigned_multiplier
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  unsigned_multiplier_if.slave  bus
);

  localparam int unsigned    CW         = count_width(WIDTH);
  localparam logic [0:0]     IDLE       = ST_IDLE;
  localparam logic [0:0]     BUSY       = ST_BUSY;
  localparam logic [CW-1:0]  COUNT_DONE = CW'(WIDTH);

  logic [0:0]          state_q,   state_d;
  logic [WIDTH-1:0]    mcand_q,   mcand_d;
  logic [2*WIDTH-1:0]  product_q, product_d;
  logic [CW-1:0]       count_q,   count_d;

  logic [2*WIDTH-1:0]  step_product;
  logic                early_exit;
  logic [2*WIDTH-1:0]  exit_product;

  shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .product_i      (product_q),
    .multiplicand_i (mcand_q),
    .product_o      (step_product)
  );

`ifdef UNSIGNED_MULTIPLIER_EARLY_EXIT_EN
  // Once every unconsumed multiplier bit is zero, the remaining iterations
  // would only shift right, so collapse them into a single shift.
  always_comb begin
    early_exit = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if ((i < (int'(WIDTH) - int'(count_q))) && product_q[i]) begin
        early_exit = 1'b0;
      end
    end
    exit_product = product_q >> (COUNT_DONE - count_q);
  end
`else
  assign early_exit   = 1'b0;
  assign exit_product = product_q;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    count_d   = count_q;

    if (bus.start) begin
      // Accepted in any state; whatever was in flight is discarded.
      mcand_d   = bus.A;
      product_d = {{WIDTH{1'b0}}, bus.B};
      count_d   = '0;
      state_d   = BUSY;
    end else if (state_q == BUSY) begin
      if (early_exit) begin
        product_d = exit_product;
        count_d   = COUNT_DONE;
        state_d   = IDLE;
      end else begin
        product_d = step_product;
        count_d   = count_q + CW'(1);
        if (count_q == COUNT_DONE - CW'(1)) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_unsigned_multiplier.sv
// Self-checking bench for unsigned_multiplier against a plain-arithmetic model.
// Latency: model predicts WIDTH cycles, or the early-exit latency when that macro is defined.
// Backpressure: none; bench issues start whenever a scenario calls for it.
module tb_unsigned_multiplier;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  unsigned_multiplier_if #(.WIDTH(W)) bus ();

  unsigned_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles from the start edge until ready is seen high again.
  function automatic int exp_latency(input logic [W-1:0] b);
    int m;
    m = -1;
    for (int i = 0; i < W; i++) begin
      if (b[i]) m = i;
    end
`ifdef UNSIGNED_MULTIPLIER_EARLY_EXIT_EN
    if (m < 0) return 1;
    return (m + 2 < W) ? m + 2 : W;
`else
    return (m < 0) ? W : W;
`endif
  endfunction

  // Drive a one-cycle start; operands are scrambled afterwards since the DUT must ignore them.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Bounded wait for ready; n is the number of edges taken (200 means timed out).
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    logic [2*W-1:0] p0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.product !== 64'd0) begin
      errors++;
      $display("FAIL reset: ready=%b product=%h, expected ready=1 product=0", bus.ready, bus.product);
    end
    @(negedge clk);
    rst = 1'b0;
    p0 = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready !== 1'b1 || bus.product !== p0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: ready=%b product=%h, expected ready=1 product=%h", i, bus.ready, bus.product, p0);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]   ta [6];
    logic [W-1:0]   tb_ [6];
    logic [2*W-1:0] tp [6];
    int n;
    ta[0] = 32'd7;         tb_[0] = 32'd6;         tp[0] = 64'd42;
    ta[1] = 32'hFFFF_FFFF; tb_[1] = 32'hFFFF_FFFF; tp[1] = 64'hFFFF_FFFE_0000_0001;
    ta[2] = 32'd0;         tb_[2] = 32'h1234_5678; tp[2] = 64'd0;
    ta[3] = 32'hDEAD_BEEF; tb_[3] = 32'd0;         tp[3] = 64'd0;
    ta[4] = 32'd5;         tb_[4] = 32'd4;         tp[4] = 64'd20;
    ta[5] = 32'd2;         tb_[5] = 32'h8000_0000; tp[5] = 64'h1_0000_0000;
    for (int k = 0; k < 6; k++) begin
      start_op(ta[k], tb_[k]);
      checks++;
      if (bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL directed_busy[%0d]: ready=%b expected 0", k, bus.ready);
      end
      wait_ready(n);
      checks++;
      if (n != exp_latency(tb_[k])) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles expected %0d", k, n, exp_latency(tb_[k]));
      end
      checks++;
      if (bus.product !== tp[k]) begin
        errors++;
        $display("FAIL directed_product[%0d]: got %h expected %h", k, bus.product, tp[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic [2*W-1:0] e;
    int n;
    for (int k = 0; k < 16; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      e = 64'(a) * 64'(b);
      start_op(a, b);
      wait_ready(n);
      checks++;
      if (n != exp_latency(b) || bus.product !== e) begin
        errors++;
        $display("FAIL random[%0d]: a=%h b=%h got %h in %0d cycles expected %h in %0d", k, a, b, bus.product, n, e, exp_latency(b));
      end
    end
  endtask

  task automatic test_restart();
    int n;
    start_op(32'd3, 32'd5);
    repeat (9) @(posedge clk);
    start_op(32'd10, 32'd10);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_busy: ready=%b expected 0", bus.ready);
    end
    wait_ready(n);
    checks++;
    if (n != exp_latency(32'd10) || bus.product !== 64'd100) begin
      errors++;
      $display("FAIL restart: got %h in %0d cycles expected 100 in %0d", bus.product, n, exp_latency(32'd10));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    int l1, n;
    a1 = $urandom; b1 = $urandom | 32'h8000_0000;
    a2 = $urandom; b2 = $urandom;
    l1 = exp_latency(b1);
    start_op(a1, b1);
    repeat (l1 - 1) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pre: ready=%b expected 0 one cycle before completion", bus.ready);
    end
    // Second start lands on the completion edge of the first.
    start_op(a2, b2);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start_wins: ready=%b expected 0", bus.ready);
    end
    wait_ready(n);
    checks++;
    if (n != exp_latency(b2) || bus.product !== 64'(a2) * 64'(b2)) begin
      errors++;
      $display("FAIL b2b_result: got %h in %0d cycles expected %h in %0d", bus.product, n, 64'(a2) * 64'(b2), exp_latency(b2));
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    start_op(32'd9, 32'd9);
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.product !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b product=%h expected ready=1 product=0", bus.ready, bus.product);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready !== 1'b1 || bus.product !== 64'd0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_after: %0d cycles deviated, expected 0", seen);
    end
  endtask

  task automatic test_rst_start();
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 32'h1357_9BDF;
    bus.B     = 32'h2468_ACE1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.product !== 64'd0) begin
      errors++;
      $display("FAIL rst_start: ready=%b product=%h expected ready=1 product=0", bus.ready, bus.product);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_start_after: ready=%b expected 1", bus.ready);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_rst_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
